cp0_exc_ctrl: RTL and testbench

- Coprocessor-0 exception/interrupt controller in the M stage of the 5-stage MIPS pipeline.
- Holds SR, Cause, EPC and PRId, and detects enabled hardware interrupts and pipeline exceptions.
- Drives intreq, which forces the next-PC mux to the 0x0000_4180 handler vector, and supplies epc as the eret return target.
- Serves mfc0/mtc0 register accesses.

---
 rtl/cp0_exc_if.sv | 26 ++
 rtl/cp0_exc_ctrl.sv | 128 ++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_exc_if.sv
// Bus between the M-stage pipeline and the CP0 exception controller:
// the instruction context, mfc0/mtc0/eret controls, and the controller's responses.
interface cp0_exc_if;
    logic [31:0] pc;
    logic        m_valid;
    logic        bd;
    logic [4:0]  exccode;
    logic [5:0]  hwint;
    logic [4:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic        eret;
    logic [31:0] rdata;
    logic [31:0] epc;
    logic        intreq;

    modport master (
        output pc, m_valid, bd, exccode, hwint, addr, we, wdata, eret,
        input  rdata, epc, intreq
    );

    modport slave (
        input  pc, m_valid, bd, exccode, hwint, addr, we, wdata, eret,
        output rdata, epc, intreq
    );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception/interrupt controller for the M stage: holds SR, Cause,
// EPC and PRId, raises intreq for enabled interrupts or exceptions, serves mfc0/mtc0.
module cp0_exc_ctrl #(
    parameter logic [31:0] PRID_VAL = 32'h4D49_5053
) (
    input  logic       clk,
    input  logic       reset_n,
    cp0_exc_if.slave   bus
);
    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [29:0] epc_q, epc_d;

    logic        int_hit_s;
    logic        exc_hit_s;
    logic        intreq_s;
    logic        sr_wr_s;
    logic        epc_wr_s;
    logic [31:0] sr_s;
    logic [31:0] cause_s;
    logic [31:0] rdata_s;
    logic [31:0] epc_s;
    logic        unused_s;

    // Interrupt/exception detection and the same-cycle EPC forward for eret.
    always_comb begin
        int_hit_s = (|(bus.hwint & im_q)) & ie_q & ~exl_q;
        exc_hit_s = (bus.exccode != 5'd0) & ~exl_q;
        intreq_s  = bus.m_valid & (int_hit_s | exc_hit_s);
        sr_wr_s   = bus.we & (bus.addr == ADDR_SR);
        epc_wr_s  = bus.we & (bus.addr == ADDR_EPC);
        sr_s      = {16'd0, im_q, 8'd0, exl_q, ie_q};
        cause_s   = {bd_q, 15'd0, ip_q, 3'd0, exccode_q, 2'd0};
        epc_s     = (epc_wr_s & ~intreq_s) ? {bus.wdata[31:2], 2'b00} : {epc_q, 2'b00};
        unused_s  = ^bus.pc[1:0];
    end

    // mfc0 read mux; returns stored contents, never the same-cycle write data.
    always_comb begin
        case (bus.addr)
            ADDR_SR:    rdata_s = sr_s;
            ADDR_CAUSE: rdata_s = cause_s;
            ADDR_EPC:   rdata_s = {epc_q, 2'b00};
            ADDR_PRID:  rdata_s = PRID_VAL;
            default:    rdata_s = 32'd0;
        endcase
    end

    // Next-state: a taken exception kills any mtc0/eret issued by the same instruction.
    always_comb begin
        im_d      = im_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        bd_d      = bd_q;
        ip_d      = bus.hwint;
        exccode_d = exccode_q;
        epc_d     = epc_q;
        if (intreq_s) begin
            exl_d = 1'b1;
            bd_d  = bus.bd;
            if (int_hit_s) begin
                exccode_d = 5'd0;
            end else begin
                exccode_d = bus.exccode;
            end
            if (bus.bd) begin
                epc_d = bus.pc[31:2] - 30'd1;
            end else begin
                epc_d = bus.pc[31:2];
            end
        end else begin
            if (sr_wr_s) begin
                im_d = bus.wdata[15:10];
                ie_d = bus.wdata[0];
            end else begin
                im_d = im_q;
                ie_d = ie_q;
            end
            // eret wins over an SR write of EXL issued in the same cycle.
            if (bus.eret) begin
                exl_d = 1'b0;
            end else if (sr_wr_s) begin
                exl_d = bus.wdata[1];
            end else begin
                exl_d = exl_q;
            end
            if (epc_wr_s) begin
                epc_d = bus.wdata[31:2];
            end else begin
                epc_d = epc_q;
            end
        end
    end

    // CP0 state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            im_q      <= 6'd0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            bd_q      <= 1'b0;
            ip_q      <= 6'd0;
            exccode_q <= 5'd0;
            epc_q     <= 30'd0;
        end else begin
            im_q      <= im_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            bd_q      <= bd_d;
            ip_q      <= ip_d;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
        end
    end

    assign bus.rdata  = rdata_s;
    assign bus.epc    = epc_s;
    assign bus.intreq = intreq_s;
endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: directed scenarios followed by randomized cycles
// checked against a register-level reference model of CP0.
module tb_cp0_exc_ctrl;
    localparam logic [31:0] PRID = 32'h4D49_5053;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   vectors = 0;
    int   errors = 0;

    logic [31:0] m_sr;
    logic [31:0] m_cause;
    logic [31:0] m_epc;

    always #5 clk = ~clk;

    cp0_exc_if bus ();

    cp0_exc_ctrl #(.PRID_VAL(PRID)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic m_int_hit();
        return ((bus.hwint & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic m_req();
        return bus.m_valid && (m_int_hit() || ((bus.exccode != 5'd0) && !m_sr[1]));
    endfunction

    function automatic logic [31:0] m_epc_out();
        if (bus.we && bus.addr == 5'd14 && !m_req()) return bus.wdata & 32'hFFFF_FFFC;
        return m_epc;
    endfunction

    function automatic logic [31:0] m_rdata();
        case (bus.addr)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_sr = 32'd0;
        m_cause = 32'd0;
        m_epc = 32'd0;
    endtask

    task automatic idle_inputs();
        bus.pc = 32'd0; bus.m_valid = 1'b1; bus.bd = 1'b0; bus.exccode = 5'd0;
        bus.hwint = 6'd0; bus.addr = 5'd0; bus.we = 1'b0; bus.wdata = 32'd0; bus.eret = 1'b0;
    endtask

    // Advance one clock and apply the architectural register rules to the model.
    task automatic tick();
        logic ih, req;
        logic [31:0] ns, nc, ne;
        @(posedge clk);
        ih = m_int_hit();
        req = m_req();
        ns = m_sr; nc = m_cause; ne = m_epc;
        nc[15:10] = bus.hwint;
        if (req) begin
            ns[1] = 1'b1;
            nc[31] = bus.bd;
            nc[6:2] = ih ? 5'd0 : bus.exccode;
            ne = (bus.pc & 32'hFFFF_FFFC) - (bus.bd ? 32'd4 : 32'd0);
        end else begin
            if (bus.we && bus.addr == 5'd12) ns = bus.wdata & 32'h0000_FC03;
            if (bus.we && bus.addr == 5'd14) ne = bus.wdata & 32'hFFFF_FFFC;
            if (bus.eret) ns[1] = 1'b0;
        end
        m_sr = ns; m_cause = nc; m_epc = ne;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        model_reset();
        bus.hwint = 6'h3F;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (bus.intreq !== 1'b0) begin errors++; $display("FAIL reset_intreq: got %0b want 0", bus.intreq); end
        bus.addr = 5'd13; #1;
        vectors++; if (bus.rdata !== 32'd0) begin errors++; $display("FAIL reset_cause: got %h want 00000000", bus.rdata); end
        reset_n = 1'b1;
        @(negedge clk);
        vectors++; if (bus.intreq !== 1'b0) begin errors++; $display("FAIL release_intreq: got %0b want 0", bus.intreq); end
        tick();
        vectors++; if (bus.rdata !== 32'h0000_FC00) begin errors++; $display("FAIL ip_capture: got %h want 0000fc00", bus.rdata); end
        bus.addr = 5'd12; #1;
        vectors++; if (bus.rdata !== 32'd0) begin errors++; $display("FAIL reset_sr: got %h want 00000000", bus.rdata); end
        bus.addr = 5'd15; #1;
        vectors++; if (bus.rdata !== PRID) begin errors++; $display("FAIL prid: got %h want %h", bus.rdata, PRID); end
        vectors++; if (bus.intreq !== 1'b0) begin errors++; $display("FAIL post_reset_intreq: got %0b want 0", bus.intreq); end
        bus.hwint = 6'd0;
        tick();
    endtask

    task automatic test_interrupt();
        idle_inputs();
        bus.we = 1'b1; bus.addr = 5'd12; bus.wdata = 32'h0000_0401; bus.hwint = 6'h01;
        @(negedge clk);
        vectors++; if (bus.intreq !== 1'b0) begin errors++; $display("FAIL sr_write_latency: got %0b want 0", bus.intreq); end
        tick();
        bus.we = 1'b0; bus.pc = 32'h3010; bus.bd = 1'b0;
        @(negedge clk);
        vectors++; if (bus.intreq !== 1'b1) begin errors++; $display("FAIL int_req: got %0b want 1", bus.intreq); end
        tick();
        bus.hwint = 6'd0; bus.addr = 5'd14;
        @(negedge clk);
        vectors++; if (bus.intreq !== 1'b0) begin errors++; $display("FAIL int_exl_block: got %0b want 0", bus.intreq); end
        vectors++; if (bus.rdata !== 32'h3010) begin errors++; $display("FAIL int_epc: got %h want 00003010", bus.rdata); end
        bus.addr = 5'd12; #1;
        vectors++; if (bus.rdata !== 32'h0000_0403) begin errors++; $display("FAIL int_sr: got %h want 00000403", bus.rdata); end
        bus.addr = 5'd13; #1;
        vectors++; if (bus.rdata !== 32'h0000_0400) begin errors++; $display("FAIL int_cause: got %h want 00000400", bus.rdata); end
        tick();
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
    endtask

    task automatic test_exception();
        idle_inputs();
        bus.exccode = 5'd4; bus.bd = 1'b1; bus.pc = 32'h3024;
        @(negedge clk);
        vectors++; if (bus.intreq !== 1'b1) begin errors++; $display("FAIL exc_req: got %0b want 1", bus.intreq); end
        tick();
        idle_inputs();
        bus.addr = 5'd14; #1;
        vectors++; if (bus.rdata !== 32'h3020) begin errors++; $display("FAIL exc_bd_epc: got %h want 00003020", bus.rdata); end
        bus.addr = 5'd13; #1;
        vectors++; if (bus.rdata !== 32'h8000_0010) begin errors++; $display("FAIL exc_cause: got %h want 80000010", bus.rdata); end
        bus.addr = 5'd12; #1;
        vectors++; if (bus.rdata !== 32'h0000_0403) begin errors++; $display("FAIL exc_sr: got %h want 00000403", bus.rdata); end
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
    endtask

    task automatic test_killed_mtc0();
        idle_inputs();
        bus.hwint = 6'h02; bus.exccode = 5'd10; bus.pc = 32'h3088;
        bus.we = 1'b1; bus.addr = 5'd14; bus.wdata = 32'h1234;
        @(negedge clk);
        vectors++; if (bus.intreq !== 1'b1) begin errors++; $display("FAIL kill_req: got %0b want 1", bus.intreq); end
        vectors++; if (bus.epc !== 32'h3020) begin errors++; $display("FAIL kill_no_fwd: got %h want 00003020", bus.epc); end
        tick();
        idle_inputs();
        bus.addr = 5'd14; #1;
        vectors++; if (bus.rdata !== 32'h3088) begin errors++; $display("FAIL kill_epc: got %h want 00003088", bus.rdata); end
        bus.addr = 5'd13; #1;
        vectors++; if (bus.rdata !== 32'h0000_0828) begin errors++; $display("FAIL kill_cause: got %h want 00000828", bus.rdata); end
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
    endtask

    task automatic test_eret_forward();
        idle_inputs();
        bus.we = 1'b1; bus.addr = 5'd12; bus.wdata = 32'h0000_0403;
        tick();
        bus.addr = 5'd14; bus.wdata = 32'h0000_3043;
        @(negedge clk);
        vectors++; if (bus.epc !== 32'h3040) begin errors++; $display("FAIL epc_fwd: got %h want 00003040", bus.epc); end
        vectors++; if (bus.rdata !== 32'h3088) begin errors++; $display("FAIL rdata_no_fwd: got %h want 00003088", bus.rdata); end
        tick();
        bus.we = 1'b0; bus.eret = 1'b1;
        @(negedge clk);
        vectors++; if (bus.epc !== 32'h3040) begin errors++; $display("FAIL eret_epc: got %h want 00003040", bus.epc); end
        tick();
        bus.eret = 1'b0; bus.addr = 5'd12; #1;
        vectors++; if (bus.rdata !== 32'h0000_0401) begin errors++; $display("FAIL eret_exl: got %h want 00000401", bus.rdata); end
    endtask

    task automatic test_bubble();
        idle_inputs();
        bus.we = 1'b1; bus.addr = 5'd12; bus.wdata = 32'h0000_1001;
        tick();
        bus.we = 1'b0; bus.hwint = 6'h04; bus.m_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.pc = 32'h3090 + 32'(4 * i);
            @(negedge clk);
            vectors++; if (bus.intreq !== 1'b0) begin errors++; $display("FAIL bubble_%0d: got %0b want 0", i, bus.intreq); end
            tick();
        end
        bus.m_valid = 1'b1; bus.pc = 32'h30A0;
        @(negedge clk);
        vectors++; if (bus.intreq !== 1'b1) begin errors++; $display("FAIL bubble_take: got %0b want 1", bus.intreq); end
        tick();
        bus.hwint = 6'd0; bus.addr = 5'd14; #1;
        vectors++; if (bus.rdata !== 32'h30A0) begin errors++; $display("FAIL bubble_epc: got %h want 000030a0", bus.rdata); end
        bus.addr = 5'd13; #1;
        vectors++; if (bus.rdata !== 32'h0000_1000) begin errors++; $display("FAIL bubble_cause: got %h want 00001000", bus.rdata); end
    endtask

    task automatic test_async_reset();
        #2;
        reset_n = 1'b0;
        model_reset();
        for (int a = 12; a <= 14; a++) begin
            bus.addr = 5'(a); #1;
            vectors++; if (bus.rdata !== 32'd0) begin errors++; $display("FAIL async_reset_reg%0d: got %h want 00000000", a, bus.rdata); end
        end
        vectors++; if (bus.epc !== 32'd0) begin errors++; $display("FAIL async_reset_epc: got %h want 00000000", bus.epc); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        int sel;
        for (int n = 0; n < 400; n++) begin
            bus.pc = $urandom & 32'h0000_FFFF;
            bus.m_valid = ($urandom_range(0, 3) != 0);
            bus.bd = $urandom_range(0, 1) == 1;
            bus.exccode = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            bus.hwint = 6'($urandom);
            sel = $urandom_range(0, 7);
            case (sel)
                0, 1, 2, 3: bus.addr = 5'(12 + sel);
                4:          bus.addr = 5'($urandom);
                5, 6:       bus.addr = 5'd12;
                default:    bus.addr = 5'd14;
            endcase
            bus.we = ($urandom_range(0, 2) == 0);
            bus.wdata = $urandom;
            bus.eret = ($urandom_range(0, 4) == 0) && !(bus.we && bus.addr == 5'd12);
            @(negedge clk);
            vectors++; if (bus.intreq !== m_req()) begin errors++; $display("FAIL rnd_intreq[%0d]: got %0b want %0b", n, bus.intreq, m_req()); end
            vectors++; if (bus.epc !== m_epc_out()) begin errors++; $display("FAIL rnd_epc[%0d]: got %h want %h", n, bus.epc, m_epc_out()); end
            vectors++; if (bus.rdata !== m_rdata()) begin errors++; $display("FAIL rnd_rdata[%0d] addr %0d: got %h want %h", n, bus.addr, bus.rdata, m_rdata()); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_interrupt();
        test_exception();
        test_killed_mtc0();
        test_eret_forward();
        test_bubble();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
